ex_div_ctrl: RTL

Multi-cycle integer divide sequencer attached to the EX stage. It captures forwarded operands for DIV/DIVU/REM/REMU and runs a radix-2 restoring division over 32 iterations. While it runs, it holds the pipeline through a stall request, then presents a one-cycle result for the EX/MEM register to capture in place of the ALU/MUL output.

---
 rtl/div_pkg.sv | 31 +++
 rtl/div_step.sv | 28 ++
 rtl/ex_div_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the EX-stage divide sequencer.
package div_pkg;

  localparam int                 DIV_XLEN   = 32;
  localparam logic [DIV_XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  // Bit 0 of the op code clear means a signed operation.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Bit 1 of the op code set means the remainder is returned.
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference if it
// did not borrow, and shift the resulting quotient bit in from the right.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            borrow;

  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs_i};
  assign borrow  = diff[XLEN+1];

  // Restore on borrow; either way the kept value fits in XLEN bits.
  always_comb begin
    rem_o = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_o = {quo_i[XLEN-2:0], ~borrow};
  end

endmodule

// File: rtl/ex_div_ctrl.sv
// EX-stage multi-cycle divide sequencer (DIV/DIVU/REM/REMU).
// Define DIV_EARLY_OUT_EN to let divide-by-zero and signed-overflow
// operations jump straight from IDLE to DONE with the override result.
module ex_div_ctrl
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN,
  parameter int RD_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [RD_W-1:0] rd_addr_in,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_addr_out
);

  localparam int              CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       op_q;
  logic [RD_W-1:0]  rd_lat_q, rd_out_q;
  logic [XLEN-1:0]  dvd_q, dvs_q, rem_q, quo_q, result_q;
  logic             q_neg_q, r_neg_q, zero_q, ovf_q;

  logic             start_ok, in_signed, in_dz, in_ovf;
  logic [XLEN-1:0]  dvd_mag, dvs_mag, step_rem, step_quo, q_fix, r_fix;

  // Picks quotient or remainder, letting the special cases override it.
  function automatic logic [XLEN-1:0] fix_result(
    input logic [1:0]      op,
    input logic            dz,
    input logic            ovf,
    input logic [XLEN-1:0] dvd,
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r
  );
    if (dz)  return op_is_rem(op) ? dvd : XLEN'(DIV_ZERO_Q);
    if (ovf) return op_is_rem(op) ? '0 : INT_MIN;
    return op_is_rem(op) ? r : q;
  endfunction

  assign start_ok  = start & ~flush & (state_q == IDLE);
  assign in_signed = op_is_signed(div_op);
  assign in_dz     = (divisor == '0);
  assign in_ovf    = in_signed & (dividend == INT_MIN) & (divisor == '1);
  assign dvd_mag   = (in_signed & dividend[XLEN-1]) ? -dividend : dividend;
  assign dvs_mag   = (in_signed & divisor[XLEN-1])  ? -divisor  : divisor;
  assign count_d   = count_q + CNT_W'(1);
  assign q_fix     = q_neg_q ? -quo_q : quo_q;
  assign r_fix     = r_neg_q ? -rem_q : rem_q;

  assign stall_req    = start_ok | (state_q == CALC) | (state_q == FIX);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;
  assign rd_addr_out  = rd_out_q;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Sequencer FSM: capture, iterate, sign-fix, present for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      rd_lat_q <= '0;
      rd_out_q <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            op_q     <= div_op;
            rd_lat_q <= rd_addr_in;
            dvd_q    <= dividend;
            dvs_q    <= dvs_mag;
            rem_q    <= '0;
            quo_q    <= dvd_mag;
            count_q  <= '0;
            q_neg_q  <= in_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            r_neg_q  <= in_signed & dividend[XLEN-1];
            zero_q   <= in_dz;
            ovf_q    <= in_ovf;
`ifdef DIV_EARLY_OUT_EN
            if (in_dz | in_ovf) begin
              result_q <= fix_result(div_op, in_dz, in_ovf, dividend, '0, '0);
              rd_out_q <= rd_addr_in;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
`else
            state_q  <= CALC;
`endif
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            rem_q   <= step_rem;
            quo_q   <= step_quo;
            count_q <= count_d;
            if (count_q == CNT_W'(XLEN - 1)) state_q <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            result_q <= fix_result(op_q, zero_q, ovf_q, dvd_q, q_fix, r_fix);
            rd_out_q <= rd_lat_q;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
